// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM microphone front end. Generates the PDM bit clock,
// counts ones over a power-of-two window, scales the count to a signed
// PCM word and queues it in a 2-entry FIFO for a valid/ready consumer.
//
// Ports:
//   clock_i     system clock, rising edge
//   reset_i     synchronous active-low reset
//   enable_i    run enable; low stops the bit clock and drops any partial window
//   pdm_clk_o   PDM bit clock to the microphone
//   pdm_data_i  PDM bit stream (already synchronised)
//   sample_o    signed PCM sample at the FIFO head
//   valid_o     sample_o is valid
//   ready_i     consumer takes sample_o when valid_o is also high
//   overflow_o  sticky: a sample was dropped because the FIFO was full
module pdm_decimator #(
    parameter int WORD_LENGTH        = 16,
    parameter int SYSTEM_FREQUENCY   = 100,
    parameter int SAMPLING_FREQUENCY = 10,
    parameter int DECIMATION         = 64
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    output logic                   pdm_clk_o,
    input  logic                   pdm_data_i,
    output logic [WORD_LENGTH-1:0] sample_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overflow_o
);

    localparam int HALF   = SYSTEM_FREQUENCY / (2 * SAMPLING_FREQUENCY);
    localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int LOG_D  = $clog2(DECIMATION);
    localparam int SHIFT  = WORD_LENGTH - 1 - LOG_D;
    localparam int CALC_W = WORD_LENGTH + 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [LOG_D-1:0] BIT_LAST = LOG_D'(DECIMATION - 1);
    localparam logic [LOG_D:0] ONES_FULL = (LOG_D + 1)'(DECIMATION);
    localparam logic [WORD_LENGTH-1:0] MAX_POS =
        {1'b0, {(WORD_LENGTH - 1){1'b1}}};

    // ------------------------------------------------------------------
    // Bit clock divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             capture;

    assign tick    = enable_i && (div == DIV_LAST);
    // Sample the mic on the edge that ends the high phase.
    assign capture = tick && pdm_clk_o;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            div       <= '0;
            pdm_clk_o <= 1'b0;
        end else if (!enable_i) begin
            div       <= '0;
            pdm_clk_o <= 1'b0;
        end else if (tick) begin
            div       <= '0;
            pdm_clk_o <= ~pdm_clk_o;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Window accumulation and scaling
    // ------------------------------------------------------------------
    logic [LOG_D-1:0]       bit_cnt;
    logic [LOG_D:0]         ones;
    logic [LOG_D:0]         ones_next;
    logic                   close;
    logic [CALC_W-1:0]      ones_ext;
    logic [CALC_W-1:0]      diff;
    logic [CALC_W-1:0]      scaled;
    logic [WORD_LENGTH-1:0] word;
    logic                   pend;
    logic [WORD_LENGTH-1:0] pend_data;

    assign ones_next = ones + {{LOG_D{1'b0}}, pdm_data_i};
    assign close     = capture && (bit_cnt == BIT_LAST);

    // (2*ones - D) << SHIFT done modulo 2^CALC_W; the low bits are the
    // exact two's complement result except for the all-ones window,
    // which would reach +2^(W-1) and is clamped instead.
    always_comb begin
        ones_ext = CALC_W'(ones_next);
        diff     = (ones_ext << 1) - CALC_W'(DECIMATION);
        scaled   = diff << SHIFT;
        if (ones_next == ONES_FULL) begin
            word = MAX_POS;
        end else begin
            word = scaled[WORD_LENGTH-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            bit_cnt   <= '0;
            ones      <= '0;
            pend      <= 1'b0;
            pend_data <= '0;
        end else begin
            pend <= close;
            if (close) begin
                pend_data <= word;
            end
            if (!enable_i) begin
                bit_cnt <= '0;
                ones    <= '0;
            end else if (capture) begin
                if (close) begin
                    bit_cnt <= '0;
                    ones    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + LOG_D'(1);
                    ones    <= ones_next;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO; outputs are registered copies of the head
    // ------------------------------------------------------------------
    logic [1:0][WORD_LENGTH-1:0] mem;
    logic [1:0][WORD_LENGTH-1:0] mem_n;
    logic                        rd_ptr;
    logic                        rd_n;
    logic                        wr_ptr;
    logic                        wr_n;
    logic [1:0]                  count;
    logic [1:0]                  count_n;
    logic                        pop;
    logic                        drop;

    assign pop = valid_o && ready_i;

    // Pop is applied before push so a full FIFO that is being read
    // this cycle still accepts the new sample.
    always_comb begin
        mem_n   = mem;
        rd_n    = rd_ptr;
        wr_n    = wr_ptr;
        count_n = count;
        drop    = 1'b0;
        if (pop) begin
            rd_n    = ~rd_ptr;
            count_n = count - 2'd1;
        end
        if (pend) begin
            if (count_n == 2'd2) begin
                drop = 1'b1;
            end else begin
                mem_n[wr_ptr] = pend_data;
                wr_n          = ~wr_ptr;
                count_n       = count_n + 2'd1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            mem        <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            valid_o    <= 1'b0;
            sample_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            mem        <= mem_n;
            rd_ptr     <= rd_n;
            wr_ptr     <= wr_n;
            count      <= count_n;
            valid_o    <= (count_n != 2'd0);
            overflow_o <= overflow_o | drop;
            if (count_n != 2'd0) begin
                sample_o <= mem_n[rd_n];
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: directed windows with hand-computed samples pushed
// to a scoreboard; a monitor compares every accepted output sample.
`timescale 1ns/1ps
module tb_pdm_decimator;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        pdm_clk_o;
    logic        pdm_data_i = 1'b0;
    logic [15:0] sample_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        overflow_o;

    pdm_decimator dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .pdm_clk_o  (pdm_clk_o),
        .pdm_data_i (pdm_data_i),
        .sample_o   (sample_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .overflow_o (overflow_o)
    );

    always #5 clock_i = ~clock_i;

    localparam logic [63:0] P_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] P_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] P_ALT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] P_48   = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] P_16   = 64'hFFFF_0000_0000_0000;
    localparam logic [63:0] P_1    = 64'h0000_0000_0000_0001;
    localparam logic [63:0] P_63   = 64'hFFFF_FFFF_FFFF_FFFE;
    localparam logic [63:0] P_33   = 64'h0000_0001_FFFF_FFFF;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic [63:0] pat_q[$];
    logic [15:0] mon_exp;

    logic [63:0] win_pat = '0;
    int          bidx = 0;
    int          closes = 0;
    bit          need_load = 1'b1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic step();
        @(posedge clock_i);
        #2;
    endtask

    task automatic issue(input logic [63:0] pat, input logic [15:0] e,
                         input bit kept);
        pat_q.push_back(pat);
        if (kept) exp_q.push_back(e);
    endtask

    task automatic wait_closes(input int target, input int budget,
                               input string name);
        int n = 0;
        while (closes < target && n < budget) begin
            step();
            n++;
        end
        if (closes < target) timeout(name);
    endtask

    task automatic wait_bits(input int nb, input string name);
        int n = 0;
        while (bidx < nb && n < 1000) begin
            step();
            n++;
        end
        if (bidx < nb) timeout(name);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) timeout(name);
    endtask

    task automatic measure_latency(output int cnt);
        cnt = 0;
        while (cnt < 2000) begin
            @(negedge clock_i);
            cnt++;
            if (valid_o) break;
        end
    endtask

    // PDM source: tracks captures from the bit clock it observes, feeds
    // bits of the current window pattern and counts closed windows.
    initial begin
        logic clk_prev;
        logic en_s;
        logic rst_s;
        clk_prev = 1'b0;
        forever begin
            @(posedge clock_i);
            #1;
            en_s  = enable_i;
            rst_s = reset_i;
            if (rst_s && en_s && clk_prev && !pdm_clk_o) begin
                if (bidx == 63) begin
                    bidx = 0;
                    closes++;
                    need_load = 1'b1;
                end else begin
                    bidx++;
                end
            end else if ((!rst_s || !en_s) && bidx != 0) begin
                bidx = 0;
                need_load = 1'b1;
            end
            clk_prev = pdm_clk_o;
            if (need_load && bidx == 0 && pat_q.size() > 0) begin
                win_pat = pat_q.pop_front();
                need_load = 1'b0;
            end
            pdm_data_i = win_pat[bidx];
        end
    end

    // Monitor: every accepted transfer is checked against the scoreboard.
    always @(negedge clock_i) begin
        if (reset_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_sample: got %h, required none",
                         sample_o);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample", {16'h0, sample_o}, {16'h0, mon_exp});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int per;
        int seen;
        int n;
        int c0;
        logic pv;

        // Reset state
        repeat (3) step();
        @(negedge clock_i);
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_overflow", {31'h0, overflow_o}, 32'h0);
        check("rst_pdm_clk", {31'h0, pdm_clk_o}, 32'h0);
        check("rst_sample", {16'h0, sample_o}, 32'h0);
        step();
        reset_i = 1'b1;
        step();

        // All zeros: first-sample latency and bit clock period
        ready_i = 1'b1;
        issue(P_ZERO, 16'h8000, 1'b1);
        step();
        enable_i = 1'b1;
        measure_latency(lat);
        check("first_valid_latency", lat, 32'd642);
        per = 0;
        seen = 0;
        n = 0;
        pv = pdm_clk_o;
        while (seen < 2 && n < 100) begin
            @(negedge clock_i);
            n++;
            if (seen == 1) per++;
            if (!pv && pdm_clk_o) seen++;
            pv = pdm_clk_o;
        end
        check("pdm_clk_period", per, 32'd10);
        step();
        enable_i = 1'b0;
        drain(100, "drain_zero");

        // Back-to-back windows of varied density
        issue(P_ONES, 16'h7FFF, 1'b1);
        issue(P_ALT, 16'h0000, 1'b1);
        issue(P_48, 16'h4000, 1'b1);
        issue(P_16, 16'hC000, 1'b1);
        issue(P_1, 16'h8400, 1'b1);
        issue(P_63, 16'h7C00, 1'b1);
        issue(P_33, 16'h0400, 1'b1);
        step();
        c0 = closes;
        enable_i = 1'b1;
        wait_closes(c0 + 7, 7 * 640 + 200, "wait_stream");
        enable_i = 1'b0;
        drain(100, "drain_stream");

        // Stalled consumer: third sample dropped
        ready_i = 1'b0;
        issue(P_48, 16'h4000, 1'b1);
        issue(P_16, 16'hC000, 1'b1);
        issue(P_ONES, 16'h0000, 1'b0);
        step();
        c0 = closes;
        enable_i = 1'b1;
        wait_closes(c0 + 3, 3 * 640 + 200, "wait_overflow");
        repeat (3) step();
        enable_i = 1'b0;
        repeat (2) step();
        @(negedge clock_i);
        check("overflow_set", {31'h0, overflow_o}, 32'h1);
        check("full_valid", {31'h0, valid_o}, 32'h1);
        check("head_hold", {16'h0, sample_o}, 32'h4000);
        step();
        ready_i = 1'b1;
        drain(20, "drain_overflow");
        repeat (2) step();
        @(negedge clock_i);
        check("drained_valid", {31'h0, valid_o}, 32'h0);
        check("overflow_sticky", {31'h0, overflow_o}, 32'h1);
        step();
        enable_i = 1'b1;
        repeat (25) step();
        enable_i = 1'b0;
        step();
        @(negedge clock_i);
        check("overflow_after_enable", {31'h0, overflow_o}, 32'h1);

        // Reset mid-window with one sample queued
        ready_i = 1'b0;
        issue(P_ONES, 16'h0000, 1'b0);
        issue(P_ONES, 16'h0000, 1'b0);
        issue(P_33, 16'h0400, 1'b1);
        step();
        c0 = closes;
        enable_i = 1'b1;
        wait_closes(c0 + 1, 900, "wait_pre_reset");
        wait_bits(30, "wait_bits_reset");
        reset_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clock_i);
        @(negedge clock_i);
        check("mid_rst_valid", {31'h0, valid_o}, 32'h0);
        check("mid_rst_overflow", {31'h0, overflow_o}, 32'h0);
        check("mid_rst_pdm_clk", {31'h0, pdm_clk_o}, 32'h0);
        check("mid_rst_sample", {16'h0, sample_o}, 32'h0);
        step();
        reset_i = 1'b1;
        measure_latency(lat);
        check("post_reset_latency", lat, 32'd642);
        step();
        enable_i = 1'b0;
        drain(100, "drain_reset");

        // Push into a full FIFO on the same cycle as a pop
        ready_i = 1'b0;
        issue(P_48, 16'h4000, 1'b1);
        issue(P_16, 16'hC000, 1'b1);
        issue(P_63, 16'h7C00, 1'b1);
        step();
        c0 = closes;
        enable_i = 1'b1;
        wait_closes(c0 + 3, 3 * 640 + 200, "wait_full_pushpop");
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        @(negedge clock_i);
        check("pushpop_overflow", {31'h0, overflow_o}, 32'h0);
        check("pushpop_head", {16'h0, sample_o}, 32'hC000);
        step();
        enable_i = 1'b0;
        ready_i = 1'b1;
        drain(50, "drain_pushpop");

        // Abort after 30 bits, then a fresh window
        issue(P_ONES, 16'h0000, 1'b0);
        issue(P_ZERO, 16'h8000, 1'b1);
        step();
        enable_i = 1'b1;
        wait_bits(30, "wait_bits_abort");
        enable_i = 1'b0;
        step();
        @(negedge clock_i);
        check("disabled_pdm_clk", {31'h0, pdm_clk_o}, 32'h0);
        repeat (10) step();
        @(negedge clock_i);
        check("disabled_pdm_clk_hold", {31'h0, pdm_clk_o}, 32'h0);
        check("disabled_valid", {31'h0, valid_o}, 32'h0);
        step();
        c0 = closes;
        enable_i = 1'b1;
        wait_closes(c0 + 1, 900, "wait_reenable");
        step();
        enable_i = 1'b0;
        drain(50, "drain_reenable");
        repeat (5) step();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_decimator.md
PDM_DECIMATOR -- requirements
Module: pdm_decimator

Interface
REQ-001 Parameter WORD_LENGTH, default 16: output sample width in bits (signed two's complement).
REQ-002 Parameter SYSTEM_FREQUENCY, default 100: system clock frequency in MHz.
REQ-003 Parameter SAMPLING_FREQUENCY, default 10: PDM bit-clock frequency in MHz; HALF = SYSTEM_FREQUENCY/(2*SAMPLING_FREQUENCY), integer and >= 1.
REQ-004 Parameter DECIMATION, default 64: PDM bits per output sample; power of two, 2 <= DECIMATION <= 2^(WORD_LENGTH-1).
REQ-005 clock_i  input  1  system clock; all logic on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-low reset.
REQ-007 enable_i  input  1  run/capture enable from the controller.
REQ-008 pdm_clk_o  output  1  PDM microphone bit clock.
REQ-009 pdm_data_i  input  1  PDM bit stream from the microphone (pre-synchronised).
REQ-010 sample_o  output  WORD_LENGTH  signed PCM sample at the FIFO head.
REQ-011 valid_o  output  1  sample_o holds a valid sample.
REQ-012 ready_i  input  1  consumer (memory write path) accepts sample_o this cycle.
REQ-013 overflow_o  output  1  sticky flag: at least one sample has been dropped.

Function
REQ-014 Clock gen: while enable_i=1, pdm_clk_o is registered and toggles every HALF system cycles; the first rising edge occurs HALF cycles after enable_i rises.
REQ-015 While enable_i=0: pdm_clk_o=0, divider cleared, bit counter and ones accumulator cleared.
REQ-016 Bit capture: pdm_data_i is sampled on the system edge at which pdm_clk_o goes 1->0 (end of the high phase); exactly one bit per PDM period.
REQ-017 Window: ones counter (log2(DECIMATION)+1 bits) counts captured 1-bits; bit counter wraps 0..DECIMATION-1.
REQ-018 Window close: on capture of bit DECIMATION-1, compute S = (2*ones - DECIMATION) << (WORD_LENGTH-1-log2(DECIMATION)); the next window starts from zero on the next capture, with no lost bits.
REQ-019 Saturation: ones=DECIMATION yields max positive (0x7FFF for 16 bits); ones=0 yields min negative (0x8000); no other value saturates.
REQ-020 Latency: S is written into the output FIFO on the cycle after the closing capture; valid_o rises one cycle after that when the FIFO was empty.
REQ-021 FIFO: 2 entries, in-order; sample_o/valid_o driven from registers; sample_o holds stable while valid_o=1 and ready_i=0.
REQ-022 Transfer occurs on a cycle with valid_o=1 and ready_i=1; the head pops on that edge; ready_i while valid_o=0 has no effect.
REQ-023 Simultaneous push and pop on a full FIFO: the pop is processed first, the push is accepted, and no overflow occurs.
REQ-024 Push with the FIFO full and no pop: the new sample is discarded, stored entries are unchanged, and overflow_o is set.
REQ-025 overflow_o clears only on reset; enable_i does not clear it.
REQ-026 enable_i falling mid-window discards the partial window; no sample is produced, and FIFO contents remain and drain normally.
REQ-027 enable_i re-asserted starts a fresh window (bit count 0).

Reset
REQ-028 reset_i=0 at a clock edge: pdm_clk_o=0, valid_o=0, sample_o=0, overflow_o=0, FIFO empty, all counters 0.
REQ-029 Reset overrides enable_i and ready_i, and takes effect mid-window or mid-transfer with no sample emitted.

Verification
REQ-030 Defaults, enable_i=1, pdm_data_i=0, ready_i=1 -> pdm_clk_o period 10 cycles; first valid_o about 642 cycles after enable; sample_o=0x8000.
REQ-031 pdm_data_i=1 constant -> sample_o=0x7FFF (saturated); alternating bits per PDM period -> sample_o=0x0000.
REQ-032 ready_i=0 across 3 window closes -> FIFO holds samples 1 and 2, the third is dropped, and overflow_o=1; then ready_i=1 -> samples 1 and 2 delivered in order, valid_o=0.
REQ-033 enable_i dropped after 30 bits, then re-raised -> pdm_clk_o=0 while disabled; the next sample reflects only the 64 bits after re-enable.
REQ-034 reset_i=0 mid-window with FIFO holding 1 sample -> next cycle valid_o=0, overflow_o=0, pdm_clk_o=0; after release the first sample takes the full latency.
REQ-035 Full FIFO with ready_i=1 on the push cycle -> no overflow, and ordering is preserved.
